// File: rtl/cla4_adder.sv
// cla4_adder: 4-bit carry-lookahead adder with group P/G outputs
// and an optional one-cycle registered copy of the sum, carry and valid flag.
module cla4_adder #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       vld_i,
    output logic [3:0] s,
    output logic       co,
    output logic       pg,
    output logic       gg,
    output logic [3:0] s_q,
    output logic       co_q,
    output logic       vld_q
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a & b;
    assign p = a ^ b;
    // Every carry is a flat sum of products of g, p and ci, so no carry waits on another.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign pg   = &p;
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign c[4] = gg | (pg & ci);
    assign s    = p ^ c[3:0];
    assign co   = c[4];
    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_q   <= 4'b0;
                    co_q  <= 1'b0;
                    vld_q <= 1'b0;
                end else begin
                    s_q   <= s;
                    co_q  <= co;
                    vld_q <= vld_i;
                end
            end
        end else begin : g_noreg
            assign s_q   = 4'b0;
            assign co_q  = 1'b0;
            assign vld_q = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_cla4_adder.sv
// tb_cla4_adder: checks the combinational adder against integer addition and
// the registered copy through a scoreboard queue, including async reset.
module tb_cla4_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       ci, vld_i;
    logic [3:0] s, s_q;
    logic       co, pg, gg, co_q, vld_q;

    typedef struct packed {
        logic [3:0] s;
        logic       co;
        logic       vld;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    cla4_adder #(.REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .vld_i(vld_i),
        .s(s), .co(co), .pg(pg), .gg(gg),
        .s_q(s_q), .co_q(co_q), .vld_q(vld_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic tci, input logic tv);
        logic [4:0] sum;
        logic [4:0] sum_nc;
        exp_t       e;
        @(negedge clk);
        a = ta; b = tb; ci = tci; vld_i = tv;
        #1;
        sum    = {1'b0, ta} + {1'b0, tb} + {4'b0, tci};
        sum_nc = {1'b0, ta} + {1'b0, tb};
        chk("sum", {3'b0, co, s}, {3'b0, sum});
        chk("pg", {7'b0, pg}, {7'b0, &(ta ^ tb)});
        chk("gg", {7'b0, gg}, {7'b0, sum_nc[4]});
        e = '{s: sum[3:0], co: sum[4], vld: tv};
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) chk("sb_empty", 8'd1, 8'd0);
        else begin
            e = q.pop_front();
            chk("s_q", {4'b0, s_q}, {4'b0, e.s});
            chk("co_q", {7'b0, co_q}, {7'b0, e.co});
            chk("vld_q", {7'b0, vld_q}, {7'b0, e.vld});
        end
    endtask

    initial begin
        rst = 1'b1; a = 4'h0; b = 4'h0; ci = 1'b0; vld_i = 1'b0;
        #12;
        chk("rst_s_q", {4'b0, s_q}, 8'h00);
        chk("rst_co_q", {7'b0, co_q}, 8'h00);
        chk("rst_vld_q", {7'b0, vld_q}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        apply(4'b0000, 4'b0000, 1'b0, 1'b1);
        apply(4'b0011, 4'b0011, 1'b0, 1'b1);
        apply(4'b1100, 4'b1100, 1'b1, 1'b0);
        apply(4'b1100, 4'b0011, 1'b1, 1'b1);
        apply(4'b1111, 4'b1111, 1'b0, 1'b1);
        // Reset mid-cycle must clear the registered copy before the next edge.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_s_q", {4'b0, s_q}, 8'h00);
        chk("arst_co_q", {7'b0, co_q}, 8'h00);
        chk("arst_vld_q", {7'b0, vld_q}, 8'h00);
        q.delete();
        @(posedge clk);
        #1;
        chk("hold_s_q", {4'b0, s_q}, 8'h00);
        chk("hold_vld_q", {7'b0, vld_q}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 512; i++)
            apply(i[3:0], i[7:4], i[8], 1'($urandom_range(0, 1)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
